// File: rtl/mesh_router_xy.sv
// mesh_router_xy: parametrised 5-port XY mesh router with input FIFOs,
// per-output round-robin arbitration and one-slot-skid flow control.
// Port index order: 0=local, 1=north, 2=south, 3=east, 4=west.
// Ports:
//   clk, reset          - router clock, synchronous active-high reset
//   in_data/in_write_en - upstream flits and write strobes, per port
//   in_full             - registered backpressure to upstream
//   out_data            - registered output flits, per port
//   out_write_req       - one-cycle write strobe to downstream
//   out_neighbor_full   - downstream backpressure, per output
//   drop_cnt            - dropped-write counter
// Optional feature: define ROUTER_DROP_CNT_EN to build the saturating
// dropped-write counter; otherwise drop_cnt is tied to zero.
module mesh_router_xy #(
  parameter int unsigned FLIT_W = 32,
  parameter int unsigned X_W    = 2,
  parameter int unsigned Y_W    = 2,
  parameter int unsigned MY_X   = 0,
  parameter int unsigned MY_Y   = 0,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5*FLIT_W-1:0] in_data,
  input  logic [4:0]          in_write_en,
  output logic [4:0]          in_full,
  output logic [5*FLIT_W-1:0] out_data,
  output logic [4:0]          out_write_req,
  input  logic [4:0]          out_neighbor_full,
  output logic [15:0]         drop_cnt
);

  localparam int unsigned NP = 5;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_SOUTH = 3'd2;
  localparam logic [2:0] P_EAST  = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;

  logic [FLIT_W-1:0] mem [NP][DEPTH];
  logic [PW-1:0]     rd_ptr [NP];
  logic [PW-1:0]     wr_ptr [NP];
  logic [CW-1:0]     count [NP];
  logic [2:0]        rr_ptr [NP];

  logic [FLIT_W-1:0] head_c [NP];
  logic [2:0]        route_c [NP];
  logic [CW-1:0]     count_nxt_c [NP];
  logic [NP-1:0]     push_c;
  logic [NP-1:0]     pop_c;
  logic [NP-1:0]     gnt_vld_c;
  logic [2:0]        gnt_idx_c [NP];

  // XY route of each FIFO head: resolve X first, then Y, else local
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      head_c[p] = mem[p][rd_ptr[p]];
      if (head_c[p][X_W-1:0] > X_W'(MY_X))
        route_c[p] = P_EAST;
      else if (head_c[p][X_W-1:0] < X_W'(MY_X))
        route_c[p] = P_WEST;
      else if (head_c[p][X_W+Y_W-1:X_W] > Y_W'(MY_Y))
        route_c[p] = P_NORTH;
      else if (head_c[p][X_W+Y_W-1:X_W] < Y_W'(MY_Y))
        route_c[p] = P_SOUTH;
      else
        route_c[p] = P_LOCAL;
    end
  end

  // Round-robin grant per output, starting at rr_ptr and wrapping mod 5
  always_comb begin
    int idx;
    gnt_vld_c = '0;
    pop_c     = '0;
    idx       = 0;
    for (int o = 0; o < NP; o++) begin
      gnt_idx_c[o] = '0;
      if (!out_neighbor_full[o]) begin
        for (int k = 0; k < NP; k++) begin
          idx = 32'(rr_ptr[o]) + k;
          if (idx >= NP) idx = idx - NP;
          if (!gnt_vld_c[o] && (count[idx] != '0) && (route_c[idx] == 3'(o))) begin
            gnt_vld_c[o] = 1'b1;
            gnt_idx_c[o] = 3'(idx);
          end
        end
      end
    end
    for (int p = 0; p < NP; p++)
      for (int o = 0; o < NP; o++)
        if (gnt_vld_c[o] && (gnt_idx_c[o] == 3'(p))) pop_c[p] = 1'b1;
  end

  // FIFO push acceptance and next occupancy
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      push_c[p]      = in_write_en[p] && (count[p] < CW'(DEPTH));
      count_nxt_c[p] = count[p] + CW'(push_c[p]) - CW'(pop_c[p]);
    end
  end

  // FIFO storage; occupancy is tracked separately so no reset is needed here
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (push_c[p]) mem[p][wr_ptr[p]] <= in_data[p*FLIT_W +: FLIT_W];
  end

  // FIFO pointers, skid-aware full flag, arbiter pointers and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        count[p]  <= '0;
        rr_ptr[p] <= '0;
      end
      in_full       <= '0;
      out_write_req <= '0;
      out_data      <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (push_c[p]) wr_ptr[p] <= wr_ptr[p] + PW'(1);
        if (pop_c[p])  rd_ptr[p] <= rd_ptr[p] + PW'(1);
        count[p]   <= count_nxt_c[p];
        // One slot of headroom absorbs the upstream grant-to-strobe delay
        in_full[p] <= (count_nxt_c[p] >= CW'(DEPTH - 1));
      end
      for (int o = 0; o < NP; o++) begin
        out_write_req[o] <= gnt_vld_c[o];
        if (gnt_vld_c[o]) begin
          out_data[o*FLIT_W +: FLIT_W] <= head_c[gnt_idx_c[o]];
          rr_ptr[o] <= (gnt_idx_c[o] == 3'(NP - 1)) ? 3'd0 : gnt_idx_c[o] + 3'd1;
        end
      end
    end
  end

`ifdef ROUTER_DROP_CNT_EN
  logic [NP-1:0] drop_c;
  logic [2:0]    drop_sum_c;
  logic [16:0]   drop_acc_c;

  // Count every port whose write arrives at a full FIFO, saturating at 16'hFFFF
  always_comb begin
    drop_sum_c = '0;
    for (int p = 0; p < NP; p++) begin
      drop_c[p]  = in_write_en[p] && (count[p] == CW'(DEPTH));
      drop_sum_c = drop_sum_c + 3'(drop_c[p]);
    end
    drop_acc_c = 17'(drop_cnt) + 17'(drop_sum_c);
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt <= '0;
    else       drop_cnt <= drop_acc_c[16] ? 16'hFFFF : drop_acc_c[15:0];
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mesh_router_xy.sv
// tb_mesh_router_xy: directed test of mesh_router_xy at node (1,1), DEPTH=4.
module tb_mesh_router_xy;

  localparam int unsigned FW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [5*FW-1:0] in_data;
  logic [4:0]      in_write_en;
  logic [4:0]      in_full;
  logic [5*FW-1:0] out_data;
  logic [4:0]      out_write_req;
  logic [4:0]      out_neighbor_full;
  logic [15:0]     drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  mesh_router_xy #(
    .FLIT_W(FW), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1), .DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_write_en(in_write_en),
    .in_full(in_full),
    .out_data(out_data),
    .out_write_req(out_write_req),
    .out_neighbor_full(out_neighbor_full),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input logic [31:0] f);
    in_data[p*FW +: FW] = f;
    in_write_en[p]      = 1'b1;
  endtask

  function automatic logic [31:0] od(input int o);
    return out_data[o*FW +: FW];
  endfunction

  logic [31:0] rt_flit [4] = '{32'hA000_0003, 32'hB000_0000, 32'hC000_0001, 32'hD000_0005};
  int          rt_out  [4] = '{3, 4, 2, 0};
  logic [31:0] ct_flit [3] = '{32'h1100_0003, 32'h2200_0003, 32'h4400_0003};
  logic [31:0] exp_drop;

  initial begin
    reset = 1'b1;
    in_data = '0;
    in_write_en = '0;
    out_neighbor_full = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_req",  32'(out_write_req), 32'h0);
    chk("rst_full", 32'(in_full), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_data", 32'(|out_data), 32'h0);

    // Latency: west -> north, strobe two cycles after the write
    put(4, 32'h0000_0009);
    tick();
    in_write_en = '0;
    chk("lat_n1", 32'(out_write_req), 32'h0);
    tick();
    chk("lat_n2_req",  32'(out_write_req), 32'h02);
    chk("lat_n2_data", od(1), 32'h0000_0009);
    tick();
    chk("lat_n3", 32'(out_write_req), 32'h0);

    // Routing from local to each direction
    for (int i = 0; i < 4; i++) begin
      put(0, rt_flit[i]);
      tick();
      in_write_en = '0;
      tick();
      chk($sformatf("route%0d_req", i),  32'(out_write_req), 32'(1 << rt_out[i]));
      chk($sformatf("route%0d_data", i), od(rt_out[i]), rt_flit[i]);
      tick();
      chk($sformatf("route%0d_idle", i), 32'(out_write_req), 32'h0);
    end

    // Contention on east: north, south, west in rr order
    reset = 1'b1;
    tick();
    reset = 1'b0;
    put(1, ct_flit[0]);
    put(2, ct_flit[1]);
    put(4, ct_flit[2]);
    tick();
    in_write_en = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cont%0d_req", i),  32'(out_write_req), 32'h08);
      chk($sformatf("cont%0d_data", i), od(3), ct_flit[i]);
      tick();
    end
    chk("cont_idle", 32'(out_write_req), 32'h0);
    // Pointer back at 0: local wins over north
    put(0, 32'h0000_0007);
    put(1, 32'h1000_0007);
    tick();
    in_write_en = '0;
    tick();
    chk("rr_first",  od(3), 32'h0000_0007);
    tick();
    chk("rr_second", od(3), 32'h1000_0007);
    tick();
    chk("rr_idle", 32'(out_write_req), 32'h0);

    // Backpressure: fill local FIFO with east blocked
    out_neighbor_full = 5'b01000;
    for (int k = 0; k < 4; k++) begin
      put(0, 32'hE000_0003 | (32'(k) << 8));
      tick();
      in_write_en = '0;
      chk($sformatf("bp_full%0d", k), 32'(in_full[0]), (k >= 2) ? 32'h1 : 32'h0);
    end
    put(0, 32'hEEEE_0003);
    tick();
    in_write_en = '0;
`ifdef ROUTER_DROP_CNT_EN
    exp_drop = 32'h1;
`else
    exp_drop = 32'h0;
`endif
    chk("bp_drop",    32'(drop_cnt), exp_drop);
    chk("bp_blocked", 32'(out_write_req), 32'h0);
    out_neighbor_full = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_drain%0d_req", k),  32'(out_write_req), 32'h08);
      chk($sformatf("bp_drain%0d_data", k), od(3), 32'hE000_0003 | (32'(k) << 8));
      tick();
    end
    chk("bp_idle",     32'(out_write_req), 32'h0);
    chk("bp_full_end", 32'(in_full[0]), 32'h0);

    // Simultaneous push and pop at count 2
    out_neighbor_full = 5'b01000;
    put(0, 32'hF000_0003);
    tick();
    put(0, 32'hF100_0003);
    tick();
    in_write_en = '0;
    chk("pp_pre_full", 32'(in_full[0]), 32'h0);
    out_neighbor_full = '0;
    put(0, 32'hF200_0003);
    tick();
    in_write_en = '0;
    chk("pp_full", 32'(in_full[0]), 32'h0);
    chk("pp_d0",   od(3), 32'hF000_0003);
    tick();
    chk("pp_d1", od(3), 32'hF100_0003);
    tick();
    chk("pp_d2_req", 32'(out_write_req), 32'h08);
    chk("pp_d2",     od(3), 32'hF200_0003);
    tick();
    chk("pp_idle", 32'(out_write_req), 32'h0);

    // Reset with three flits buffered
    out_neighbor_full = 5'b01000;
    for (int k = 0; k < 3; k++) begin
      put(0, 32'h5500_0003 | (32'(k) << 8));
      tick();
    end
    in_write_en = '0;
    chk("mr_full_pre", 32'(in_full[0]), 32'h1);
    out_neighbor_full = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mr_req%0d", i), 32'(out_write_req), 32'h0);
      tick();
    end
    chk("mr_full", 32'(in_full), 32'h0);
    chk("mr_drop", 32'(drop_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
